operand_fetch_scoreboard: RTL and testbench

Interlock controller in front of the register-fetch stage of the SimpleRISC pipeline. Takes decoded instructions from decode and resolves source/destination register indices, including the ret→r15 and st→rd read-port muxing. Stalls any instruction whose sources have in-flight writes, and hands hazard-free instructions to execute through a registered valid/ready stage. Tracks outstanding writes per register and releases them on writeback.

---
 rtl/operand_fetch_scoreboard.sv | 93 +++++++++
 tb/tb_operand_fetch_scoreboard.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_scoreboard.sv
// operand_fetch_scoreboard: register interlock between decode and execute with per-register write tracking
// Ports: clk/rst (sync, active high); in_* decode handshake and instruction flags;
// out_* registered instruction stage to execute; wb_valid/wb_rd writeback release;
// flush drops the held instruction; busy_mask, wb_underflow, stall_cycles status.
module operand_fetch_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W = 2,
  parameter int PERF_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic                in_reads_rs1,
  input  logic                in_reads_rs2,
  input  logic                in_writes_rd,
  input  logic                in_is_ret,
  input  logic                in_is_st,
  input  logic                in_is_call,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic [REG_AW-1:0]   out_src1,
  output logic [REG_AW-1:0]   out_src2,
  output logic [REG_AW-1:0]   out_dst,
  output logic                out_writes,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                wb_underflow,
  output logic [PERF_W-1:0]   stall_cycles
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [REG_AW-1:0] LINK = REG_AW'(15);
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [REG_AW-1:0] src1, src2, dst;
  logic [NUM_REGS-1:0] inc, hit;
  logic hazard, accept, issue;
  assign src1 = in_is_ret ? LINK : in_inst[21:18];
  assign src2 = in_is_st ? in_inst[25:22] : in_inst[17:14];
  assign dst = in_is_call ? LINK : in_inst[25:22];
  // The held-but-unissued writer has not bumped its counter yet, so it must be checked separately.
  function automatic logic pend(input logic [REG_AW-1:0] x);
    return out_valid && out_writes && out_dst == x;
  endfunction
  assign hazard = (in_reads_rs1 && (cnt[src1] != '0 || pend(src1))) ||
                  (in_reads_rs2 && (cnt[src2] != '0 || pend(src2))) ||
                  (in_writes_rd && cnt[dst] == CNT_MAX);
  assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
  assign accept = in_valid && in_ready;
  assign issue = out_valid && out_ready && out_writes;
  always_comb begin
    inc = '0;
    hit = '0;
    busy_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i] = issue && out_dst == REG_AW'(i);
      hit[i] = wb_valid && wb_rd == REG_AW'(i);
      busy_mask[i] = cnt[i] != '0;
    end
  end
  // Issue and writeback on the same register cancel; a writeback on an idle counter is ignored.
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REGS; i++)
      if (rst) cnt[i] <= '0;
      else if (inc[i] != hit[i]) cnt[i] <= inc[i] ? cnt[i] + CNT_W'(1) : cnt[i] - CNT_W'(cnt[i] != '0);
  always_ff @(posedge clk) begin
    if (rst) wb_underflow <= 1'b0;
    else if (wb_valid && cnt[wb_rd] == '0) wb_underflow <= 1'b1;
    if (rst) stall_cycles <= '0;
    else if (in_valid && hazard && stall_cycles != '1) stall_cycles <= stall_cycles + PERF_W'(1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_inst <= '0;
      out_src1 <= '0;
      out_src2 <= '0;
      out_dst <= '0;
      out_writes <= 1'b0;
    end else if (flush) out_valid <= 1'b0;
    else if (accept) begin
      out_valid <= 1'b1;
      out_inst <= in_inst;
      out_src1 <= src1;
      out_src2 <= src2;
      out_dst <= dst;
      out_writes <= in_writes_rd;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_operand_fetch_scoreboard.sv
// tb_operand_fetch_scoreboard: directed and random checks of operand_fetch_scoreboard against a reference model
module tb_operand_fetch_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_ready, in_reads_rs1, in_reads_rs2, in_writes_rd, in_is_ret, in_is_st, in_is_call;
  logic out_valid, out_ready, out_writes, wb_valid, flush, wb_underflow;
  logic [31:0] in_inst, out_inst;
  logic [3:0] out_src1, out_src2, out_dst, wb_rd;
  logic [15:0] busy_mask, stall_cycles;
  operand_fetch_scoreboard dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_reads_rs1(in_reads_rs1), .in_reads_rs2(in_reads_rs2), .in_writes_rd(in_writes_rd),
    .in_is_ret(in_is_ret), .in_is_st(in_is_st), .in_is_call(in_is_call),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_src1(out_src1),
    .out_src2(out_src2), .out_dst(out_dst), .out_writes(out_writes), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .flush(flush), .busy_mask(busy_mask), .wb_underflow(wb_underflow),
    .stall_cycles(stall_cycles)
  );
  int n_cmp = 0, n_bad = 0;
  int m_cnt [16];
  bit m_ov, m_ow, m_uf, m_zchk;
  logic [31:0] m_inst;
  logic [3:0] m_s1, m_s2, m_d;
  int m_stall;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mk(input logic [3:0] rd, input logic [3:0] r1, input logic [3:0] r2);
    return {6'd0, rd, r1, r2, 14'd0};
  endfunction
  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ov = 0; m_ow = 0; m_uf = 0; m_stall = 0; m_inst = 0; m_s1 = 0; m_s2 = 0; m_d = 0; m_zchk = 1;
  endtask
  task automatic idle();
    in_valid = 0; in_inst = 0; in_reads_rs1 = 0; in_reads_rs2 = 0; in_writes_rd = 0;
    in_is_ret = 0; in_is_st = 0; in_is_call = 0; out_ready = 1; wb_valid = 0; wb_rd = 0; flush = 0; rst = 0;
  endtask
  task automatic cycle();
    logic [3:0] s1, s2, d;
    logic [15:0] bm;
    bit haz, rdy, acc, iss;
    #1;
    s1 = in_is_ret ? 4'd15 : in_inst[21:18];
    s2 = in_is_st ? in_inst[25:22] : in_inst[17:14];
    d = in_is_call ? 4'd15 : in_inst[25:22];
    haz = (in_reads_rs1 && (m_cnt[s1] != 0 || (m_ov && m_ow && m_d == s1))) ||
          (in_reads_rs2 && (m_cnt[s2] != 0 || (m_ov && m_ow && m_d == s2))) ||
          (in_writes_rd && m_cnt[d] == 3);
    rdy = !haz && (!m_ov || out_ready) && !flush;
    for (int i = 0; i < 16; i++) bm[i] = m_cnt[i] != 0;
    check("in_ready", in_ready, rdy);
    check("out_valid", out_valid, m_ov);
    check("busy_mask", busy_mask, bm);
    check("wb_underflow", wb_underflow, m_uf);
    check("stall_cycles", stall_cycles, m_stall);
    if (m_ov || m_zchk) begin
      check("out_inst", out_inst, m_inst);
      check("out_src1", out_src1, m_s1);
      check("out_src2", out_src2, m_s2);
      check("out_dst", out_dst, m_d);
      check("out_writes", out_writes, m_ow);
    end
    acc = in_valid && rdy;
    iss = m_ov && out_ready && m_ow;
    if (rst) model_reset();
    else begin
      m_zchk = 0;
      if (iss && !(wb_valid && wb_rd == m_d)) m_cnt[m_d] = (m_cnt[m_d] + 1) % 4;
      if (wb_valid) begin
        if (m_cnt[wb_rd] == 0) m_uf = 1;
        else if (!(iss && m_d == wb_rd)) m_cnt[wb_rd]--;
      end
      if (in_valid && haz && m_stall < 65535) m_stall++;
      if (flush) m_ov = 0;
      else if (acc) begin
        m_ov = 1; m_inst = in_inst; m_s1 = s1; m_s2 = s2; m_d = d; m_ow = in_writes_rd;
      end else if (out_ready) m_ov = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask
  function automatic logic [3:0] pick();
    int r = $urandom_range(0, 6);
    return r == 6 ? 4'd15 : 4'(r);
  endfunction
  task automatic rand_inputs();
    int q[$];
    in_valid = $urandom_range(0, 9) < 7;
    in_inst = $urandom;
    in_inst[25:22] = pick();
    in_inst[21:18] = pick();
    in_inst[17:14] = pick();
    in_reads_rs1 = $urandom_range(0, 1);
    in_reads_rs2 = $urandom_range(0, 1);
    in_writes_rd = $urandom_range(0, 2) != 0;
    in_is_ret = $urandom_range(0, 7) == 0;
    in_is_st = $urandom_range(0, 7) == 0;
    in_is_call = $urandom_range(0, 7) == 0;
    out_ready = $urandom_range(0, 9) < 7;
    for (int i = 0; i < 16; i++) if (m_cnt[i] != 0) q.push_back(i);
    wb_valid = 0;
    wb_rd = 0;
    if (q.size() != 0 && $urandom_range(0, 9) < 6) begin
      wb_valid = 1;
      wb_rd = 4'(q[$urandom_range(0, q.size() - 1)]);
    end else if ($urandom_range(0, 29) == 0) begin
      wb_valid = 1;
      wb_rd = pick();
    end
    flush = $urandom_range(0, 15) == 0;
    rst = $urandom_range(0, 199) == 0;
  endtask
  initial begin
    idle();
    rst = 1;
    repeat (2) @(negedge clk);
    model_reset();
    cycle();
    // RAW on r3
    idle(); in_valid = 1; in_inst = mk(3, 0, 0); in_writes_rd = 1;
    cycle();
    in_inst = mk(5, 3, 4); in_reads_rs1 = 1; in_reads_rs2 = 1;
    #1 check("raw_stall_pend", in_ready, 0);
    cycle();
    #1 check("raw_stall_cnt", in_ready, 0);
    cycle();
    wb_valid = 1; wb_rd = 3;
    #1 check("raw_stall_wb_cycle", in_ready, 0);
    cycle();
    wb_valid = 0;
    #1 check("raw_release", in_ready, 1);
    cycle();
    in_valid = 0;
    cycle();
    cycle();
    do_reset();
    // ret reads r15 written by call
    in_valid = 1; in_inst = mk(0, 0, 0); in_writes_rd = 1; in_is_call = 1;
    cycle();
    in_valid = 0;
    cycle();
    in_valid = 1; in_is_call = 0; in_writes_rd = 0; in_is_ret = 1; in_reads_rs1 = 1; in_inst = mk(0, 2, 0);
    #1 check("ret_stall", in_ready, 0);
    cycle();
    wb_valid = 1; wb_rd = 15;
    cycle();
    wb_valid = 0;
    #1 check("ret_release", in_ready, 1);
    cycle();
    in_valid = 0;
    #1 check("ret_src1", out_src1, 15);
    cycle();
    do_reset();
    // store reads its rd field on port 2
    in_valid = 1; in_inst = mk(7, 0, 0); in_writes_rd = 1;
    cycle();
    in_valid = 0;
    cycle();
    in_valid = 1; in_writes_rd = 0; in_is_st = 1; in_reads_rs2 = 1; in_inst = mk(7, 0, 1);
    #1 check("st_stall", in_ready, 0);
    cycle();
    wb_valid = 1; wb_rd = 7;
    cycle();
    wb_valid = 0;
    cycle();
    in_valid = 0;
    #1 check("st_src2", out_src2, 7);
    cycle();
    do_reset();
    // counter saturation on r9
    in_valid = 1; in_inst = mk(9, 0, 0); in_writes_rd = 1;
    repeat (3) cycle();
    in_valid = 0;
    repeat (2) cycle();
    in_valid = 1;
    #1 check("sat_stall", in_ready, 0);
    cycle();
    wb_valid = 1; wb_rd = 9;
    cycle();
    wb_valid = 0;
    #1 check("sat_release", in_ready, 1);
    cycle();
    in_valid = 0;
    // mid-stall reset
    in_valid = 1; in_inst = mk(1, 9, 0); in_reads_rs1 = 1; in_writes_rd = 0;
    cycle();
    do_reset();
    #1 check("rst_busy", busy_mask, 0);
    check("rst_stall", stall_cycles, 0);
    // underflow on idle r6
    wb_valid = 1; wb_rd = 6;
    cycle();
    wb_valid = 0;
    #1 check("underflow_set", wb_underflow, 1);
    cycle();
    // flush of a held instruction
    in_valid = 1; in_inst = mk(2, 0, 0); in_writes_rd = 1; out_ready = 0;
    cycle();
    in_valid = 0; flush = 1;
    #1 check("flush_held", out_valid, 1);
    cycle();
    flush = 0;
    #1 check("flush_clear", out_valid, 0);
    check("flush_busy", busy_mask, 0);
    cycle();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rand_inputs();
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
